// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
// Holds the FSM state encoding, alignment mask and default widths.
package mem_stage_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [1:0] MISALIGN_MASK = 2'b11;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/mem_timeout_counter.sv
// Saturating wait counter for outstanding memory accesses.
// expired is high while the count sits on the last permitted wait cycle.
module mem_timeout_counter
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;

  assign expired = (count_q == LAST);

  // Holds at LAST instead of wrapping; the FSM leaves ACCESS on that cycle anyway.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: word load/store over a req/ack data-memory port,
// with pass-through of ALU results, misalignment and timeout reporting.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              SelectMem,
  input  logic              WE,
  input  logic [DATA_W-1:0] ALURESULT,
  input  logic [DATA_W-1:0] Data2,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic [DATA_W-1:0] Data5,
  output logic              misalign,
  output logic              bus_err
);

  state_t            state_q;
  logic [DATA_W-1:0] alu_q;
  logic              aligned;
  logic              start_mem;
  logic              waiting;
  logic              expired;

  assign aligned   = ((ALURESULT[1:0] & MISALIGN_MASK) == 2'b00);
  assign start_mem = (state_q == IDLE) && ex_valid && SelectMem && aligned;
  assign waiting   = (state_q == ACCESS) && !mem_ack;
  // Gated by reset so the stage reports no stall while held in reset.
  assign stall     = rst_n && (start_mem || waiting);

  mem_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (start_mem),
    .enable  (waiting),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      alu_q     <= '0;
      wb_valid  <= 1'b0;
      Data5     <= '0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ex_valid) begin
            if (!SelectMem) begin
              wb_valid <= 1'b1;
              Data5    <= ALURESULT;
            end else if (!aligned) begin
              misalign <= 1'b1;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= WE;
              mem_addr  <= ALURESULT[ADDR_W+1:2];
              mem_wdata <= Data2;
              alu_q     <= ALURESULT;
              state_q   <= ACCESS;
            end
          end
        end
        ACCESS: begin
          // Ack is checked first so a completion on the last wait cycle beats the timeout.
          if (mem_ack) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            wb_valid <= 1'b1;
            Data5    <= mem_we ? alu_q : mem_rdata;
            state_q  <= IDLE;
          end else if (expired) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            bus_err <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
